// File: rtl/ram512_word16_pkg.sv
// rtl/ram512_word16_pkg.sv - shared widths, depths and word type for the RAM hierarchy
package ram512_word16_pkg;

  localparam int DATA_W = 16;

  localparam int RAM8_DEPTH    = 8;
  localparam int RAM8_ADDR_W   = 3;
  localparam int RAM64_DEPTH   = 64;
  localparam int RAM64_ADDR_W  = 6;
  localparam int RAM512_DEPTH  = 512;
  localparam int RAM512_ADDR_W = 9;

  // Upper address bits beyond the bank width pick one of the 64-word banks.
  localparam int NUM_BANKS  = RAM512_DEPTH / RAM64_DEPTH;
  localparam int BANK_SEL_W = RAM512_ADDR_W - RAM64_ADDR_W;

  typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/ram512_word16_if.sv
// rtl/ram512_word16_if.sv - access port bundle for the 512-word RAM
interface ram512_word16_if #(
  parameter int DATA_W = ram512_word16_pkg::DATA_W,
  parameter int ADDR_W = ram512_word16_pkg::RAM512_ADDR_W
) ();

  logic [DATA_W-1:0] in_i;
  logic              load_i;
  logic [ADDR_W-1:0] address_i;
  logic [DATA_W-1:0] out_o;

  modport master (
    output in_i,
    output load_i,
    output address_i,
    input  out_o
  );

  modport slave (
    input  in_i,
    input  load_i,
    input  address_i,
    output out_o
  );

endinterface

// File: rtl/ram512_word16_ram64.sv
// rtl/ram512_word16_ram64.sv - 64 x 16 bank: synchronous write, combinational read
module ram64_word16
  import ram512_word16_pkg::*;
(
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  word_t                   in_i,
  input  logic                    load_i,
  input  logic [RAM64_ADDR_W-1:0] address_i,
  output word_t                   out_o
);

  word_t mem_q [RAM64_DEPTH];
  word_t mem_d [RAM64_DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (load_i) begin
      mem_d[address_i] = in_i;
    end
  end

  // Reset wins over a pending write even when it arrives mid-cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign out_o = mem_q[address_i];

endmodule

// File: rtl/ram512_word16.sv
// rtl/ram512_word16.sv - 512 x 16 RAM built from eight 64-word banks
module ram512_word16
  import ram512_word16_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  ram512_word16_if.slave   bus
);

  logic [BANK_SEL_W-1:0]   bank_sel;
  logic [RAM64_ADDR_W-1:0] word_sel;
  logic [NUM_BANKS-1:0]    bank_load;
  word_t                   bank_out [NUM_BANKS];

  assign bank_sel = bus.address_i[RAM512_ADDR_W-1:RAM64_ADDR_W];
  assign word_sel = bus.address_i[RAM64_ADDR_W-1:0];

  always_comb begin
    bank_load           = '0;
    bank_load[bank_sel] = bus.load_i;
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    ram64_word16 u_bank (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_i      (bus.in_i),
      .load_i    (bank_load[b]),
      .address_i (word_sel),
      .out_o     (bank_out[b])
    );
  end

  assign bus.out_o = bank_out[bank_sel];

endmodule

// File: tb/tb_ram512_word16.sv
// tb/tb_ram512_word16.sv - self-checking bench for ram512_word16 against an array model
module tb_ram512_word16;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;

  ram512_word16_if #(.DATA_W(16), .ADDR_W(9)) bus ();

  ram512_word16 dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  logic [15:0] model [512];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input logic [8:0] a);
    bus.address_i = a;
    #1;
    check(tag, bus.out_o, model[a]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 512; i++) model[i] = 16'h0000;
  endtask

  task automatic do_write(input logic [8:0] a, input logic [15:0] d);
    @(negedge clk_i);
    bus.address_i = a;
    bus.in_i      = d;
    bus.load_i    = 1'b1;
    @(posedge clk_i);
    #1;
    bus.load_i = 1'b0;
    model[a]   = d;
  endtask

  logic [8:0]  wr_addr [8];
  logic [15:0] wr_data [8];

  initial begin
    logic [8:0]  ra;
    logic [15:0] rd;
    logic        rl;

    wr_addr = '{9'h000, 9'h049, 9'h092, 9'h0DB, 9'h124, 9'h16D, 9'h1B6, 9'h1FF};
    wr_data = '{16'h0000, 16'h8285, 16'hFEB9, 16'h2B67, 16'h0001, 16'h0021, 16'hF000, 16'h3039};
    clear_model();
    bus.in_i      = 16'h0000;
    bus.load_i    = 1'b0;
    bus.address_i = 9'h000;

    // Reset held, no edge yet
    #1;
    check("reset_0", bus.out_o, 16'h0000);
    read_chk("reset_049", 9'h049);
    read_chk("reset_1ff", 9'h1FF);

    // Write attempted during reset
    @(negedge clk_i);
    bus.address_i = 9'h049;
    bus.in_i      = 16'hBEEF;
    bus.load_i    = 1'b1;
    @(posedge clk_i);
    #1;
    check("write_in_reset", bus.out_o, 16'h0000);
    @(negedge clk_i);
    bus.load_i = 1'b0;
    rst_i      = 1'b0;

    // Directed write pattern, then read-only sweep with in_i = 1
    for (int i = 0; i < 8; i++) do_write(wr_addr[i], wr_data[i]);
    @(negedge clk_i);
    bus.in_i = 16'h0001;
    for (int i = 0; i < 8; i++) begin
      bus.address_i = wr_addr[i];
      @(posedge clk_i);
      #1;
      check($sformatf("sweep_%0h", wr_addr[i]), bus.out_o, wr_data[i]);
    end

    // Combinational read between edges
    @(negedge clk_i);
    bus.address_i = 9'h049;
    #1;
    check("comb_049", bus.out_o, 16'h8285);
    bus.address_i = 9'h1FF;
    #1;
    check("comb_1ff", bus.out_o, 16'h3039);

    // Read during write
    @(negedge clk_i);
    bus.address_i = 9'h092;
    bus.in_i      = 16'h1234;
    bus.load_i    = 1'b1;
    #1;
    check("rdw_before", bus.out_o, 16'hFEB9);
    @(posedge clk_i);
    #1;
    bus.load_i = 1'b0;
    model[9'h092] = 16'h1234;
    check("rdw_after", bus.out_o, 16'h1234);

    // Bank isolation at the 63/64 boundary
    do_write(9'h03F, 16'hAAAA);
    do_write(9'h040, 16'h5555);
    read_chk("iso_03f", 9'h03F);
    read_chk("iso_040", 9'h040);
    read_chk("iso_000", 9'h000);
    read_chk("iso_1c0", 9'h1C0);
    check("iso_03f_const", model[9'h03F], 16'hAAAA);

    // Mid-cycle reset with a write pending: memory clears and the write is lost
    @(negedge clk_i);
    bus.address_i = 9'h0DB;
    bus.in_i      = 16'h7777;
    bus.load_i    = 1'b1;
    #2;
    rst_i = 1'b1;
    #1;
    check("midrst_0db", bus.out_o, 16'h0000);
    clear_model();
    @(posedge clk_i);
    #1;
    check("midrst_discard", bus.out_o, 16'h0000);
    @(negedge clk_i);
    bus.load_i = 1'b0;
    rst_i      = 1'b0;
    do_write(9'h100, 16'h0007);
    check("post_rst_100", bus.out_o, 16'h0007);
    for (int a = 0; a < 512; a++) read_chk("post_rst_sweep", 9'(a));

    // Randomised traffic with occasional short reset pulses
    for (int i = 0; i < 400; i++) begin
      ra = 9'($urandom_range(0, 511));
      rd = 16'($urandom);
      rl = 1'($urandom_range(0, 1));
      @(negedge clk_i);
      if ($urandom_range(0, 39) == 0) begin
        #1;
        rst_i = 1'b1;
        bus.address_i = ra;
        #1;
        clear_model();
        check("rnd_rst", bus.out_o, 16'h0000);
        rst_i = 1'b0;
        #1;
      end
      bus.address_i = ra;
      bus.in_i      = rd;
      bus.load_i    = rl;
      #1;
      check("rnd_before", bus.out_o, model[ra]);
      @(posedge clk_i);
      #1;
      if (rl) model[ra] = rd;
      check("rnd_after", bus.out_o, model[ra]);
      bus.load_i = 1'b0;
    end
    for (int a = 0; a < 512; a++) read_chk("final_sweep", 9'(a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
